// File: rtl/ysyx_25020037_icache_sa.sv
// ysyx_25020037_icache_sa: set-associative instruction cache with round-robin replacement and fence.i flush.
// Define YSYX_25020037_ICACHE_PERF_EN to build the hit/miss performance counters.
module ysyx_25020037_icache_sa #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WAYS       = 2,
  parameter int SETS       = 8,
  parameter int BLOCK_SIZE = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fence_i,
  input  logic                    cpu_req,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  output logic [DATA_WIDTH-1:0]   cpu_data,
  output logic                    cpu_hit,
  output logic                    cpu_ready,
  output logic                    mem_req,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [BLOCK_SIZE*8-1:0] mem_data,
  input  logic                    mem_ready,
  output logic [31:0]             perf_hit_cnt,
  output logic [31:0]             perf_miss_cnt
);
  localparam int OFF = $clog2(BLOCK_SIZE);
  localparam int IW  = $clog2(SETS);
  localparam int TW  = ADDR_WIDTH - OFF - IW;
  localparam int WW  = WAYS > 1 ? $clog2(WAYS) : 1;
  localparam int LW  = BLOCK_SIZE * 8;

  typedef enum logic [1:0] {IDLE, COMPARE, REFILL, FENCE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    pend_q, pend_d;
  logic [WAYS-1:0]         valid_q [SETS];
  logic [WAYS-1:0]         valid_d [SETS];
  logic [WW-1:0]           rr_q [SETS];
  logic [WW-1:0]           rr_d [SETS];
  logic [TW-1:0]           tag_q [SETS][WAYS];
  logic [LW-1:0]           line_q [SETS][WAYS];
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    ready_q, ready_d, hit_q, hit_d;
  logic [IW-1:0]           idx;
  logic [TW-1:0]           tag;
  logic                    hit, found_inv, we;
  logic [WW-1:0]           hit_way, vic;

  function automatic logic [DATA_WIDTH-1:0] word_of(input logic [LW-1:0] l, input logic [OFF-1:0] o);
    return DATA_WIDTH'(l >> {o, 3'b000});
  endfunction

  assign idx = addr_q[OFF+:IW];
  assign tag = addr_q[OFF+IW+:TW];

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    found_inv = 1'b0;
    vic       = rr_q[idx];
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
      if (!valid_q[idx][w] && !found_inv) begin
        found_inv = 1'b1;
        vic       = WW'(w);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pend_d  = pend_q | (fence_i && state_q != IDLE);
    valid_d = valid_q;
    rr_d    = rr_q;
    data_d  = '0;
    ready_d = 1'b0;
    hit_d   = 1'b0;
    we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (fence_i || pend_q) state_d = FENCE;
        else if (cpu_req) begin
          state_d = COMPARE;
          addr_d  = cpu_addr;
        end
      end
      COMPARE: begin
        state_d = hit ? IDLE : REFILL;
        ready_d = hit;
        hit_d   = hit;
        data_d  = hit ? word_of(line_q[idx][hit_way], addr_q[OFF-1:0]) : '0;
      end
      REFILL: begin
        if (mem_ready) begin
          state_d           = IDLE;
          we                = 1'b1;
          valid_d[idx][vic] = 1'b1;
          if (!found_inv) rr_d[idx] = rr_q[idx] == WW'(WAYS - 1) ? '0 : rr_q[idx] + 1'b1;
          ready_d           = 1'b1;
          data_d            = word_of(mem_data, addr_q[OFF-1:0]);
        end
      end
      default: begin
        state_d = IDLE;
        pend_d  = fence_i;
        ready_d = 1'b1;
        for (int s = 0; s < SETS; s++) begin
          valid_d[s] = '0;
          rr_d[s]    = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      pend_q  <= 1'b0;
      valid_q <= '{default: '0};
      rr_q    <= '{default: '0};
      data_q  <= '0;
      ready_q <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      rr_q    <= rr_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      hit_q   <= hit_d;
    end
  end

  // Tag/data storage is left unreset; validity alone decides residency.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      tag_q[idx][vic]  <= tag;
      line_q[idx][vic] <= mem_data;
    end
  end

  assign cpu_data  = data_q;
  assign cpu_hit   = hit_q;
  assign cpu_ready = ready_q;
  assign mem_req   = state_q == REFILL;
  assign mem_addr  = {addr_q[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};

`ifdef YSYX_25020037_ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q + 32'(state_q == COMPARE && hit);
    miss_cnt_d = miss_cnt_q + 32'(state_q == COMPARE && !hit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign perf_hit_cnt  = hit_cnt_q;
  assign perf_miss_cnt = miss_cnt_q;
`else
  assign perf_hit_cnt  = '0;
  assign perf_miss_cnt = '0;
`endif
endmodule

// File: tb/tb_ysyx_25020037_icache_sa.sv
// tb_ysyx_25020037_icache_sa: directed table, corner sequences and randomized fetches against a cache-content model.
module tb_ysyx_25020037_icache_sa;
  logic         clk = 1'b0;
  logic         rst, fence_i, cpu_req, mem_ready;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_data;
  logic         cpu_hit, cpu_ready, mem_req;
  logic [31:0]  mem_addr;
  logic [127:0] mem_data;
  logic [31:0]  perf_hit_cnt, perf_miss_cnt;

  int errors = 0;
  int checks = 0;
  int exp_hits = 0;
  int exp_miss = 0;

  logic        mv  [8][2];
  logic [27:0] mla [8][2];
  int          mrr [8];

  typedef struct {
    logic [31:0] addr;
    int          lat;
    logic        exp_hit;
  } vec_t;

  ysyx_25020037_icache_sa dut (
    .clk(clk), .rst(rst), .fence_i(fence_i), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_data(cpu_data), .cpu_hit(cpu_hit), .cpu_ready(cpu_ready), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .perf_hit_cnt(perf_hit_cnt), .perf_miss_cnt(perf_miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a == 32'h8000_0004 ? 32'h1111_1111 : (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[k*32+:32] = mem_word({a[31:4], 4'b0} + 32'(k * 4));
    return l;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < 8; s++) begin
      mrr[s] = 0;
      for (int w = 0; w < 2; w++) mv[s][w] = 1'b0;
    end
  endfunction

  function automatic logic model_hit(input logic [31:0] a);
    int s = int'(a[6:4]);
    for (int w = 0; w < 2; w++) if (mv[s][w] && mla[s][w] == a[31:4]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_fill(input logic [31:0] a);
    int s = int'(a[6:4]);
    int v = -1;
    for (int w = 1; w >= 0; w--) if (!mv[s][w]) v = w;
    if (v < 0) begin
      v = mrr[s];
      mrr[s] = (mrr[s] + 1) % 2;
    end
    mv[s][v]  = 1'b1;
    mla[s][v] = a[31:4];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_clear();
    exp_hits = 0;
    exp_miss = 0;
  endtask

  task automatic fetch(input logic [31:0] a, input int lat, output logic ok, output logic h,
                       output logic [31:0] d, output int cyc, output logic sawreq,
                       output logic [31:0] ma, output logic bad);
    int n = 0;
    ok = 0; h = 0; d = 0; cyc = 0; sawreq = 0; ma = 0; bad = 0;
    cpu_req  = 1'b1;
    cpu_addr = a;
    tick();
    cpu_req  = 1'b0;
    cpu_addr = $urandom;
    while (!ok && cyc < 40) begin
      if (mem_req) begin
        if (!sawreq) ma = mem_addr;
        else if (mem_addr !== ma) bad = 1'b1;
        sawreq = 1'b1;
        if (n >= lat) begin
          mem_ready = 1'b1;
          mem_data  = line_of(ma);
        end
        n++;
      end else begin
        if (sawreq) bad = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
        mem_data  = {$urandom, $urandom, $urandom, $urandom};
      end
      if (cpu_data !== 32'h0) bad = 1'b1;
      tick();
      mem_ready = 1'b0;
      cyc++;
      if (cpu_ready) begin
        ok = 1'b1;
        h  = cpu_hit;
        d  = cpu_data;
      end
    end
  endtask

  task automatic run(input logic [31:0] a, input int lat, input logic eh);
    logic ok, h, sawreq, bad;
    logic [31:0] d, ma;
    int cyc;
    fetch(a, lat, ok, h, d, cyc, sawreq, ma, bad);
    chk($sformatf("ready@%h", a), ok, 1);
    chk($sformatf("hit@%h", a), h, eh);
    chk($sformatf("data@%h", a), d, mem_word(a));
    chk($sformatf("mem_req_seen@%h", a), sawreq, !eh);
    chk($sformatf("protocol@%h", a), bad, 0);
    if (eh) begin
      chk($sformatf("hit_latency@%h", a), cyc, 1);
      exp_hits++;
    end else begin
      chk($sformatf("mem_addr@%h", a), ma, {a[31:4], 4'b0});
      exp_miss++;
      model_fill(a);
    end
    tick();
    chk($sformatf("quiet_after@%h", a), {cpu_ready, cpu_hit, mem_req, cpu_data}, 0);
  endtask

  task automatic do_fence();
    int pulses = 0;
    logic bad = 1'b0;
    fence_i = 1'b1;
    tick();
    fence_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cpu_ready) begin
        pulses++;
        if (cpu_hit || cpu_data != 0) bad = 1'b1;
      end
      if (mem_req) bad = 1'b1;
    end
    chk("fence_pulses", pulses, 1);
    chk("fence_pulse_content", bad, 0);
    model_clear();
  endtask

  task automatic chk_perf(input string nm);
`ifdef YSYX_25020037_ICACHE_PERF_EN
    chk({nm, "_hit_cnt"}, perf_hit_cnt, exp_hits);
    chk({nm, "_miss_cnt"}, perf_miss_cnt, exp_miss);
`else
    chk({nm, "_hit_cnt"}, perf_hit_cnt, 0);
    chk({nm, "_miss_cnt"}, perf_miss_cnt, 0);
`endif
  endtask

  initial begin
    vec_t vecs[9];
    int pulses;
    logic bad;
    vecs = '{
      '{32'h8000_0004, 2, 1'b0},
      '{32'h8000_0004, 0, 1'b1},
      '{32'h8000_0000, 0, 1'b1},
      '{32'h8000_0080, 0, 1'b0},
      '{32'h8000_0100, 3, 1'b0},
      '{32'h8000_0088, 0, 1'b1},
      '{32'h8000_0000, 1, 1'b0},
      '{32'h8000_010c, 0, 1'b1},
      '{32'h8000_0080, 0, 1'b0}
    };
    rst = 1'b1; fence_i = 1'b0; cpu_req = 1'b0; cpu_addr = '0; mem_ready = 1'b0; mem_data = '0;
    tick();
    chk("reset_outputs", {cpu_ready, cpu_hit, mem_req, cpu_data}, 0);
    chk("reset_perf", {perf_hit_cnt, perf_miss_cnt}, 0);
    do_reset();
    chk("post_reset_outputs", {cpu_ready, cpu_hit, mem_req, cpu_data}, 0);

    foreach (vecs[i]) run(vecs[i].addr, vecs[i].lat, vecs[i].exp_hit);
    chk_perf("table");

    // fence_i and cpu_req together: only the fence is served
    cpu_req = 1'b1; cpu_addr = 32'h8000_0100; fence_i = 1'b1;
    tick();
    cpu_req = 1'b0; fence_i = 1'b0;
    pulses = 0; bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (cpu_ready) begin
        pulses++;
        if (cpu_hit || cpu_data != 0) bad = 1'b1;
      end
      if (mem_req) bad = 1'b1;
      tick();
    end
    chk("fence_req_pulses", pulses, 1);
    chk("fence_req_not_accepted", bad, 0);
    model_clear();
    run(32'h8000_0100, 0, 1'b0);

    // fence_i during a refill is deferred until the refill completes
    run(32'h8000_0000, 0, 1'b0);
    run(32'h8000_0000, 0, 1'b1);
    cpu_req = 1'b1; cpu_addr = 32'h8000_0040;
    tick();
    cpu_req = 1'b0;
    tick();
    chk("refill_mem_req", mem_req, 1);
    fence_i = 1'b1;
    tick();
    fence_i = 1'b0;
    chk("refill_holds_during_fence", mem_req, 1);
    mem_ready = 1'b1; mem_data = line_of(32'h8000_0040);
    tick();
    mem_ready = 1'b0;
    chk("refill_done", {cpu_ready, cpu_hit, cpu_data}, {1'b1, 1'b0, mem_word(32'h8000_0040)});
    exp_miss++;
    pulses = 0; bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cpu_ready) begin
        pulses++;
        if (cpu_hit || cpu_data != 0) bad = 1'b1;
      end
    end
    chk("deferred_fence_pulses", pulses, 1);
    chk("deferred_fence_content", bad, 0);
    model_clear();
    run(32'h8000_0000, 0, 1'b0);
    chk_perf("after_fence");

    // reset in the middle of a refill abandons it
    cpu_req = 1'b1; cpu_addr = 32'h8000_0200;
    tick();
    cpu_req = 1'b0;
    tick();
    chk("rst_refill_mem_req", mem_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    exp_hits = 0; exp_miss = 0;
    chk("rst_drops_mem_req", mem_req, 0);
    mem_ready = 1'b1; mem_data = line_of(32'h8000_0200);
    tick();
    mem_ready = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (cpu_ready || mem_req) pulses++;
      tick();
    end
    chk("rst_no_ready", pulses, 0);
    chk_perf("after_rst");
    run(32'h8000_0200, 1, 1'b0);
    run(32'h8000_0204, 0, 1'b1);
    run(32'h8000_0300, 0, 1'b0);
    run(32'h8000_0400, 2, 1'b0);
    run(32'h8000_0404, 0, 1'b1);
    chk_perf("three_miss_two_hit");

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = 32'h8000_0000 | (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 7)) << 4)
          | (32'($urandom_range(0, 3)) << 2);
      if ($urandom_range(0, 19) == 0) do_fence();
      run(a, int'($urandom_range(0, 3)), model_hit(a));
    end
    chk_perf("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ysyx_25020037_icache_sa.md
YSYX_25020037_ICACHE_SA -- requirements
Module: ysyx_25020037_icache_sa

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, fetch word width (bits).
REQ-003 SHALL have parameter WAYS, default 2, associativity; power of two, 1..8.
REQ-004 SHALL have parameter SETS, default 8, set count; power of two, >=2.
REQ-005 SHALL have parameter BLOCK_SIZE, default 16, line size in bytes; power of two, >= DATA_WIDTH/8.
REQ-006 SHALL have port clk, input, 1, the only clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-008 SHALL have port fence_i, input, 1, single-cycle request to invalidate all lines.
REQ-009 SHALL have ports cpu_req (in, 1, fetch request) and cpu_addr (in, ADDR_WIDTH, word-aligned fetch address).
REQ-010 SHALL have ports cpu_data (out, DATA_WIDTH, fetched word), cpu_hit (out, 1, request served from cache) and cpu_ready (out, 1, cpu_data valid / fence done).
REQ-011 SHALL have ports mem_req (out, 1), mem_addr (out, ADDR_WIDTH, line-aligned), mem_data (in, BLOCK_SIZE*8, refill line) and mem_ready (in, 1, mem_data valid).
REQ-012 SHALL have ports perf_hit_cnt and perf_miss_cnt, out, 32 each, event counters.

Function
REQ-013 SHALL split the address as offset = low log2(BLOCK_SIZE) bits, index = next log2(SETS) bits, tag = remaining bits.
REQ-014 SHALL use states IDLE, COMPARE, REFILL and FENCE; IDLE->FENCE if fence_i or fence pending, else IDLE->COMPARE if cpu_req; COMPARE->IDLE on hit, else ->REFILL; REFILL->IDLE on mem_ready; FENCE->IDLE.
REQ-015 SHALL register cpu_addr on IDLE->COMPARE and use only the registered address until the request completes; cpu_addr changes mid-request are ignored.
REQ-016 SHALL declare a hit when any way of the indexed set is valid with a matching tag; at most one way matches.
REQ-017 On hit, cpu_ready and cpu_hit SHALL be 1 for exactly one cycle, 2 cycles after the accepting cycle, with the addressed word on cpu_data.
REQ-018 On miss, mem_req SHALL rise in the cycle after COMPARE and stay 1, with mem_addr = {tag,index,0} stable, up to and including the mem_ready cycle; it falls the cycle after.
REQ-019 On mem_ready in REFILL, SHALL write tag, line and valid into the victim way, and the cycle after SHALL present the addressed word with cpu_ready=1, cpu_hit=0 for one cycle.
REQ-020 Victim SHALL be the lowest-numbered invalid way of the set; if all valid, the way named by that set's round-robin pointer, which then increments modulo WAYS.
REQ-021 mem_ready outside REFILL SHALL be ignored.
REQ-022 fence_i while not IDLE SHALL set a pending flag; the in-flight request completes normally, then FENCE runs before any new request.
REQ-023 fence_i and cpu_req together in IDLE SHALL serve FENCE first; cpu_req is not accepted that cycle.
REQ-024 FENCE SHALL clear all valid bits and round-robin pointers, and cpu_ready SHALL be 1 for one cycle after it with cpu_hit=0 and cpu_data=0.
REQ-025 cpu_data SHALL be 0 whenever cpu_ready is 0.

Reset
REQ-026 On rst, state SHALL be IDLE, and cpu_data, cpu_hit, cpu_ready, mem_req and the perf counters SHALL be 0.
REQ-027 On rst, all valid bits, round-robin pointers and the fence-pending flag SHALL clear; rst during REFILL abandons the refill with no line written.
REQ-028 Tag and data arrays need no reset.

Configuration
REQ-029 With macro YSYX_25020037_ICACHE_PERF_EN defined, perf_hit_cnt SHALL increment on each hit and perf_miss_cnt on each COMPARE->REFILL, both wrapping modulo 2^32 and unaffected by FENCE.
REQ-030 Without YSYX_25020037_ICACHE_PERF_EN, the perf ports SHALL remain and read constant 0, and no counter logic shall exist.

Verification (WAYS=2, SETS=8, BLOCK_SIZE=16)
REQ-031 After reset, read 0x8000_0004 -> mem_req=1, mem_addr=0x8000_0000; return line word1=0x1111_1111 -> cpu_ready=1, cpu_hit=0, cpu_data=0x1111_1111.
REQ-032 Re-read 0x8000_0004 at cycle t -> cpu_ready=cpu_hit=1 at t+2, data 0x1111_1111, mem_req stays 0.
REQ-033 Fill 0x8000_0000, 0x8000_0080, 0x8000_0100 (all set 0) -> third evicts the 0x8000_0000 line; re-read 0x8000_0000 misses, 0x8000_0080 hits.
REQ-034 Hit-prime 0x8000_0000, pulse fence_i during a refill of 0x8000_0040 -> refill completes, FENCE follows with one cpu_ready pulse, next 0x8000_0000 misses.
REQ-035 Assert rst mid-REFILL, then return mem_ready -> mem_req=0 next cycle, no cpu_ready, and the address misses again afterward.
REQ-036 With PERF_EN, 3 misses + 2 hits -> perf_miss_cnt=3, perf_hit_cnt=2; without it both read 0.
